// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller: FSM state encodings and default timeouts.
// Imported by the RTL and by the bench so that both agree on encodings and limits.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_DUMP  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int DEF_TYPE_W        = 4;
  localparam int DEF_CNT_W         = 32;
  localparam int DEF_SHORT_TIMEOUT = 512;
  localparam int DEF_LONG_TIMEOUT  = 2097152;
  localparam int DEF_LONG_TYPE_MIN = 7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Harness-side bundle of the run controller: run request/test selector in, core control and status out.
// master = harness driving start/test_type/core status; slave = run_ctrl.
interface run_ctrl_if
  import run_ctrl_pkg::*;
#(
  parameter int TYPE_W = DEF_TYPE_W,
  parameter int CNT_W  = DEF_CNT_W
);
  logic              start;
  logic [TYPE_W-1:0] test_type;
  logic              core_halt;
  logic              core_retire;
  logic              core_rst;
  logic              debug;
  logic              running;
  logic              done;
  logic              timed_out;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  retire_count;

  modport master (
    output start, test_type, core_halt, core_retire,
    input  core_rst, debug, running, done, timed_out, cycle_count, retire_count
  );

  modport slave (
    input  start, test_type, core_halt, core_retire,
    output core_rst, debug, running, done, timed_out, cycle_count, retire_count
  );
endinterface

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
// One-cycle latency from en_i/clr_i to q_o; no backpressure.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] q_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the core in reset, runs it until halt or timeout, pulses debug, reports done.
// All outputs registered (state change visible one cycle after the deciding edge); no backpressure.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int TYPE_W        = DEF_TYPE_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int RST_CYCLES    = 1,
  parameter int DEBUG_CYCLES  = 1,
  parameter int SHORT_TIMEOUT = DEF_SHORT_TIMEOUT,
  parameter int LONG_TIMEOUT  = DEF_LONG_TIMEOUT,
  parameter int LONG_TYPE_MIN = DEF_LONG_TYPE_MIN,
  parameter bit AUTO_START    = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  run_ctrl_if.slave bus
);

  // The timeout runs off its own unsaturated counter so a narrow CNT_W cannot stall it.
  localparam int LIM_W = $clog2(max_int(SHORT_TIMEOUT, LONG_TIMEOUT)) + 1;
  localparam int PH_W  = $clog2(max_int(RST_CYCLES, DEBUG_CYCLES)) + 1;

  state_e           state_q;
  logic [PH_W-1:0]  ph_q;
  logic [LIM_W-1:0] run_cnt_q;
  logic [LIM_W-1:0] lim_last_q;
  logic [LIM_W-1:0] lim_last_d;
  logic             core_rst_q;
  logic             debug_q;
  logic             running_q;
  logic             done_q;
  logic             timed_out_q;

  logic go;
  logic run_last;
  logic run_exit;
  logic cyc_en;
  logic ret_en;

  always_comb begin
    lim_last_d = (bus.test_type >= TYPE_W'(LONG_TYPE_MIN)) ? LIM_W'(LONG_TIMEOUT - 1)
                                                           : LIM_W'(SHORT_TIMEOUT - 1);
    go         = ((state_q == S_IDLE) && (bus.start || AUTO_START)) ||
                 ((state_q == S_DONE) && bus.start);
    run_last   = (run_cnt_q == lim_last_q);
    run_exit   = (state_q == S_RUN) && (bus.core_halt || run_last);
    cyc_en     = (state_q == S_RUN) && !run_exit;
    ret_en     = (state_q == S_RUN) && bus.core_retire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ph_q        <= '0;
      run_cnt_q   <= '0;
      lim_last_q  <= '0;
      core_rst_q  <= 1'b1;
      debug_q     <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (go) begin
            state_q     <= S_RESET;
            ph_q        <= '0;
            run_cnt_q   <= '0;
            lim_last_q  <= lim_last_d;
            timed_out_q <= 1'b0;
            done_q      <= 1'b0;
            core_rst_q  <= 1'b1;
          end
        end
        S_RESET: begin
          if (ph_q == PH_W'(RST_CYCLES - 1)) begin
            state_q    <= S_RUN;
            core_rst_q <= 1'b0;
            running_q  <= 1'b1;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        S_RUN: begin
          if (run_exit) begin
            // Halt takes priority over a coincident timeout.
            state_q     <= S_DUMP;
            running_q   <= 1'b0;
            debug_q     <= 1'b1;
            timed_out_q <= !bus.core_halt;
            ph_q        <= '0;
          end else begin
            run_cnt_q <= run_cnt_q + 1'b1;
          end
        end
        S_DUMP: begin
          if (ph_q == PH_W'(DEBUG_CYCLES - 1)) begin
            state_q    <= S_DONE;
            debug_q    <= 1'b0;
            done_q     <= 1'b1;
            core_rst_q <= 1'b1;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          core_rst_q <= 1'b1;
          debug_q    <= 1'b0;
          running_q  <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (go),
    .en_i  (cyc_en),
    .q_o   (bus.cycle_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (go),
    .en_i  (ret_en),
    .q_o   (bus.retire_count)
  );

  assign bus.core_rst  = core_rst_q;
  assign bus.debug     = debug_q;
  assign bus.running   = running_q;
  assign bus.done      = done_q;
  assign bus.timed_out = timed_out_q;

endmodule
